// File: rtl/mem_access_ctrl.sv
// Memory access controller: owns MAR/MDR and sequences single read or write
// cycles to a synchronous-write, combinational-read memory.
module mem_access_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              start,
    input  logic              wr,
    input  logic [DATA_W-1:0] Mdatain,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Datain,
    output logic              Write,
    output logic [DATA_W-1:0] MDRdata,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [2:0] WS_MAX = 3'(WAIT_STATES);

    logic [1:0]        state;
    logic [2:0]        wait_cnt;
    logic              wr_q;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the async clear forces the FSM and registers together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            wait_cnt <= '0;
            wr_q     <= 1'b0;
            mar      <= '0;
            mdr      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (MARin)
                        mar <= BusMuxOut[ADDR_W-1:0];
                    if (MDRin)
                        mdr <= Read ? Mdatain : BusMuxOut;
                    if (start) begin
                        wr_q     <= wr;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    if (wait_cnt == WS_MAX)
                        state <= ACCESS;
                    else
                        wait_cnt <= wait_cnt + 3'd1;
                end
                ACCESS: begin
                    // A started read always takes memory data, whatever Read says.
                    if (!wr_q)
                        mdr <= Mdatain;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from the state register so Write falls as soon as clr does.
    assign Write   = (state == ACCESS) && wr_q;
    assign busy    = (state == SETUP) || (state == ACCESS);
    assign done    = (state == DONE);
    assign Address = mar;
    assign Datain  = mdr;
    assign MDRdata = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: two instances (0 and 3 wait states),
// each with its own 512x32 memory model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] bus;
    logic        marin, mdrin, rd, start, start3, wr;

    logic [31:0] mdatain0, datain0, mdrdata0;
    logic [8:0]  addr0;
    logic        write0, busy0, done0;
    logic [31:0] mdatain3, datain3, mdrdata3;
    logic [8:0]  addr3;
    logic        write3, busy3, done3;

    logic [31:0] mem0 [0:511];
    logic [31:0] mem3 [0:511];
    int          wcount;
    int          tests = 0;
    int          errors = 0;
    int          w_before;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .clr(clr), .BusMuxOut(bus), .MARin(marin), .MDRin(mdrin),
        .Read(rd), .start(start), .wr(wr), .Mdatain(mdatain0),
        .Address(addr0), .Datain(datain0), .Write(write0), .MDRdata(mdrdata0),
        .busy(busy0), .done(done0)
    );

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(3)) dut3 (
        .clk(clk), .clr(clr), .BusMuxOut(bus), .MARin(marin), .MDRin(mdrin),
        .Read(rd), .start(start3), .wr(wr), .Mdatain(mdatain3),
        .Address(addr3), .Datain(datain3), .Write(write3), .MDRdata(mdrdata3),
        .busy(busy3), .done(done3)
    );

    assign mdatain0 = mem0[addr0];
    assign mdatain3 = mem3[addr3];

    always @(posedge clk) begin
        if (write0) begin
            mem0[addr0] <= datain0;
            wcount      <= wcount + 1;
        end
        if (write3)
            mem3[addr3] <= datain3;
    end

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 + 32'(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem0[i] = pat(i);
            mem3[i] = pat(i);
        end
        wcount = 0;
        clr = 1'b0; bus = '0; marin = 0; mdrin = 0; rd = 0;
        start = 0; start3 = 0; wr = 0;
        #12;
        check("rst_addr",  32'(addr0), 0);
        check("rst_mdr",   mdrdata0, 0);
        check("rst_busy",  32'(busy0), 0);
        check("rst_done",  32'(done0), 0);
        check("rst_write", 32'(write0), 0);
        clr = 1'b1;
        tick();

        // Write 0xDEADBEEF to 0x054, then read it back.
        bus = 32'h0000_0054; marin = 1; tick(); marin = 0;
        check("mar_load", 32'(addr0), 32'h054);
        bus = 32'hDEAD_BEEF; mdrin = 1; rd = 0; tick(); mdrin = 0;
        check("mdr_load", datain0, 32'hDEAD_BEEF);
        w_before = wcount;
        start = 1; wr = 1; tick(); start = 0;
        check("wr_setup_busy",  32'(busy0), 1);
        check("wr_setup_write", 32'(write0), 0);
        tick();
        check("wr_access_write", 32'(write0), 1);
        check("wr_access_busy",  32'(busy0), 1);
        tick();
        check("wr_done",       32'(done0), 1);
        check("wr_done_busy",  32'(busy0), 0);
        check("wr_done_write", 32'(write0), 0);
        check("wr_mem",        mem0[9'h054], 32'hDEAD_BEEF);
        check("wr_once",       32'(wcount - w_before), 1);
        tick();
        check("wr_idle_done", 32'(done0), 0);
        bus = 32'h0; mdrin = 1; tick(); mdrin = 0;
        check("mdr_clear", mdrdata0, 0);
        start = 1; wr = 0; rd = 0; tick(); start = 0;
        tick(); tick();
        check("rd_done", 32'(done0), 1);
        check("rd_data", mdrdata0, 32'hDEAD_BEEF);
        tick();

        // Three wait states: address held for 4 SETUP cycles, then one ACCESS.
        bus = 32'h0000_001F; marin = 1; tick(); marin = 0;
        start3 = 1; wr = 0; tick(); start3 = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ws_setup_busy%0d", i), 32'(busy3), 1);
            check($sformatf("ws_setup_addr%0d", i), 32'(addr3), 32'h01F);
            check($sformatf("ws_setup_done%0d", i), 32'(done3), 0);
            tick();
        end
        check("ws_access_busy", 32'(busy3), 1);
        check("ws_access_done", 32'(done3), 0);
        tick();
        check("ws_done", 32'(done3), 1);
        check("ws_data", mdrdata3, pat(32'h01F));
        tick();

        // MARin/MDRin/start held while busy must be ignored.
        w_before = wcount;
        start = 1; wr = 1; tick();
        bus = 32'h0000_00AA; marin = 1; mdrin = 1; rd = 0;
        tick();
        check("ign_access_addr", 32'(addr0), 32'h01F);
        check("ign_access_mdr",  datain0, 32'hDEAD_BEEF);
        check("ign_access_wr",   32'(write0), 1);
        tick();
        start = 0; marin = 0; mdrin = 0;
        check("ign_done",     32'(done0), 1);
        check("ign_done_mdr", mdrdata0, 32'hDEAD_BEEF);
        check("ign_mem_1f",   mem0[9'h01F], 32'hDEAD_BEEF);
        check("ign_mem_aa",   mem0[9'h0AA], pat(32'h0AA));
        check("ign_one_cyc",  32'(wcount - w_before), 1);
        tick();
        check("ign_idle_busy", 32'(busy0), 0);

        // Back-to-back: new start in DONE, with a truncating MAR load.
        start = 1; wr = 0; tick(); start = 0;
        tick(); tick();
        check("b2b_done1", 32'(done0), 1);
        start = 1; wr = 1; bus = 32'h0000_0205; marin = 1;
        tick();
        start = 0; marin = 0;
        check("b2b_busy",  32'(busy0), 1);
        check("b2b_done0", 32'(done0), 0);
        check("b2b_addr",  32'(addr0), 32'h005);
        tick();
        check("b2b_write", 32'(write0), 1);
        tick();
        check("b2b_done2", 32'(done0), 1);
        check("b2b_mem",   mem0[9'h005], 32'hDEAD_BEEF);
        tick();

        // Asynchronous reset during SETUP of a write: no write may happen.
        bus = 32'h0000_0010; marin = 1; tick(); marin = 0;
        bus = 32'h1234_5678; mdrin = 1; rd = 0; tick(); mdrin = 0;
        w_before = wcount;
        start = 1; wr = 1; tick(); start = 0;
        check("rst_mid_busy_pre", 32'(busy0), 1);
        #2 clr = 1'b0;
        #1;
        check("rst_mid_write", 32'(write0), 0);
        check("rst_mid_busy",  32'(busy0), 0);
        check("rst_mid_done",  32'(done0), 0);
        check("rst_mid_addr",  32'(addr0), 0);
        check("rst_mid_mdr",   mdrdata0, 0);
        @(posedge clk); #3 clr = 1'b1;
        tick(); tick();
        check("rst_after_busy",   32'(busy0), 0);
        check("rst_no_write",     32'(wcount - w_before), 0);
        check("rst_mem_intact",   mem0[9'h010], pat(32'h010));
        bus = 32'h0000_0010; marin = 1; tick(); marin = 0;
        start = 1; wr = 0; tick(); start = 0;
        tick(); tick();
        check("rst_rd_done", 32'(done0), 1);
        check("rst_rd_data", mdrdata0, pat(32'h010));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the 512x32 main memory: owns MAR and MDR and sequences every read and write cycle.
- Memory interface it drives: synchronous write on the clk rising edge when Write=1; combinational read data for the current Address.
- Sits between the datapath bus (BusMuxOut) and the memory block, and gives the control unit a start/busy/done handshake.

Parameters:
- ADDR_W, 9, memory address width; MAR holds BusMuxOut[ADDR_W-1:0].
- DATA_W, 32, data width of MDR, bus and memory.
- WAIT_STATES, 0, extra cycles the address is held stable before the access cycle (0..7).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- BusMuxOut  in  DATA_W  datapath bus.
- MARin  in  1  load MAR from BusMuxOut[ADDR_W-1:0].
- MDRin  in  1  load MDR; source selected by Read.
- Read  in  1  MDR source select for a direct MDRin load: 1 = Mdatain, 0 = BusMuxOut.
- start  in  1  request a memory cycle.
- wr  in  1  cycle type, sampled with start: 1 = write, 0 = read.
- Mdatain  in  DATA_W  read data from memory.
- Address  out  ADDR_W  to memory; always equals MAR.
- Datain  out  DATA_W  to memory; always equals MDR.
- Write  out  1  memory write enable.
- MDRdata  out  DATA_W  MDR contents, to the bus mux.
- busy  out  1  cycle in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (clr=0, asynchronous):
  - MAR=0, MDR=0, state=IDLE, wait counter=0, latched wr=0.
  - Outputs: Write=0, busy=0, done=0, Address=0, Datain=0, MDRdata=0.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - MARin and MDRin are honoured; both may load in the same cycle.
  - start=1 latches wr, clears the wait counter, and moves to SETUP.
- SETUP:
  - busy=1; MAR, MDR and latched wr are frozen; MARin and MDRin are ignored.
  - Lasts WAIT_STATES+1 cycles (the counter counts up to WAIT_STATES), then moves to ACCESS.
- ACCESS:
  - Exactly one cycle; busy=1.
  - Write = latched wr, decoded from the state register; Write is 0 in every other state.
  - Write cycle: memory captures Datain=MDR at the closing edge.
  - Read cycle: MDR <= Mdatain at the closing edge.
  - Moves to DONE.
- DONE:
  - Exactly one cycle; done=1, busy=0.
  - Read result is valid on MDRdata.
  - MARin and MDRin are honoured, as in IDLE.
  - start=1 here is accepted exactly as in IDLE (back-to-back cycles); otherwise return to IDLE.
- Latency: start sampled at edge k gives done high in the cycle after edge k+WAIT_STATES+2. With WAIT_STATES=0, done is high in the cycle after edge k+2, i.e. 3 cycles from the start-sampling edge.
- Ignored inputs:
  - start while busy=1 is ignored, not queued.
  - MARin and MDRin while busy=1 are ignored.
- Read only affects direct MDRin loads. A start-initiated read always captures Mdatain regardless of Read.
- Reset mid-operation:
  - Write drops immediately, asynchronously.
  - If clr is asserted before the ACCESS closing edge, no memory write occurs and MDR returns to 0.
  - After release the block is in IDLE; a new start is required.
- MAR width: MAR loads BusMuxOut[ADDR_W-1:0]; upper bus bits are discarded (e.g. 0x0000_0205 gives Address 0x005).
- Address wraps naturally within 2^ADDR_W; no bounds checking.

Test Plan:
1. Reset: drive clr=0 mid-simulation, asynchronously, between edges -> Write, busy, done, Address, MDRdata all 0 immediately.
2. Write then read back (WAIT_STATES=0):
   - BusMuxOut=0x0000_0054 with MARin; BusMuxOut=0xDEAD_BEEF with MDRin, Read=0; start with wr=1 -> Write high for exactly 1 cycle; done 3 cycles after the start-sampling edge.
   - Then clear MDR; start with wr=0 -> MDRdata=0xDEAD_BEEF when done is high.
3. WAIT_STATES=3 read of preloaded address 0x01F -> Address stable for 4 SETUP cycles; done after 6 cycles; MDR equals the memory word.
4. start, MARin=1 (BusMuxOut=0x0AA) and MDRin asserted during SETUP and ACCESS -> MAR and MDR unchanged by those loads; exactly one memory cycle occurs.
5. Back-to-back: start asserted during DONE -> busy reasserts on the next cycle with no IDLE gap. BusMuxOut=0x0000_0205 with MARin -> Address=0x005.
6. Reset mid-write: clr=0 during SETUP of a write of 0x1234_5678 to 0x010 -> Write never asserts; a subsequent read of 0x010 returns its prior contents.
